// File: rtl/high_score_pkg.sv
`default_nettype none
// ============================================================================
// Module   : high_score_pkg
// Brief    : Shared score type and ranking FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package high_score_pkg;

    localparam int SCORE_W = 10;

    typedef logic [SCORE_W-1:0] score_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } hs_state_t;

endpackage : high_score_pkg
`default_nettype wire

// File: rtl/high_score_cmp.sv
`default_nettype none
// ============================================================================
// Module   : high_score_cmp
// Brief    : 10-bit unsigned magnitude comparator, out = (a > b).
// Revision : 1.0 - initial release
// ============================================================================
module high_score_cmp
    import high_score_pkg::*;
(
    input  score_t a,
    input  score_t b,
    output logic   out
);

    assign out = (a > b);

endmodule : high_score_cmp
`default_nettype wire

// File: rtl/high_score_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : high_score_ctrl
// Brief    : Ranks player scores through one shared comparator and maintains
//            the persistent high score. Optional macro HS_CLEAR_EN adds the
//            clear_hs input.
// Revision : 1.0 - initial release
// ============================================================================
module high_score_ctrl
    import high_score_pkg::*;
#(
    parameter int     NUM_PLAYERS = 4,
    parameter score_t HS_INIT     = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [SCORE_W*NUM_PLAYERS-1:0] scores,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(NUM_PLAYERS)-1:0] winner,
    output score_t                         best_score,
    output score_t                         high_score,
    output logic                           new_record
`ifdef HS_CLEAR_EN
    ,
    input  logic                           clear_hs
`endif
);

    localparam int c_IDX_W = $clog2(NUM_PLAYERS);

    localparam logic [1:0] c_S_IDLE  = IDLE;
    localparam logic [1:0] c_S_SCAN  = SCAN;
    localparam logic [1:0] c_S_CHECK = CHECK;
    localparam logic [1:0] c_S_DONE  = DONE;

    localparam logic [c_IDX_W-1:0] c_LAST_PTR = c_IDX_W'(NUM_PLAYERS - 1);

    logic [1:0]         r_state;
    score_t             r_snap [NUM_PLAYERS];
    logic [c_IDX_W-1:0] r_ptr;
    logic [c_IDX_W-1:0] r_idx;
    score_t             r_best;
    score_t             r_high_score;
    logic               r_new_record;
    logic [c_IDX_W-1:0] r_winner;
    score_t             r_best_score;

    score_t             w_score [NUM_PLAYERS];
    score_t             w_cmp_a;
    score_t             w_cmp_b;
    logic               w_gt;
    logic               w_clear;

    genvar p;
    generate
        for (p = 0; p < NUM_PLAYERS; p++) begin : g_unpack
            assign w_score[p] = scores[SCORE_W*p +: SCORE_W];
        end
    endgenerate

`ifdef HS_CLEAR_EN
    assign w_clear = clear_hs;
`else
    assign w_clear = 1'b0;
`endif

    // SCAN ranks snapshot entries against the running best; any other state
    // points the comparator at best vs. the stored high score.
    always_comb begin
        w_cmp_a = r_best;
        w_cmp_b = r_high_score;
        if (r_state == c_S_SCAN) begin
            w_cmp_a = r_snap[r_ptr];
            w_cmp_b = r_best;
        end
    end

    high_score_cmp u_cmp (
        .a   (w_cmp_a),
        .b   (w_cmp_b),
        .out (w_gt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_S_IDLE;
            r_ptr        <= '0;
            r_idx        <= '0;
            r_best       <= '0;
            r_high_score <= HS_INIT;
            r_new_record <= 1'b0;
            r_winner     <= '0;
            r_best_score <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_clear) begin
                        r_high_score <= HS_INIT;
                        r_new_record <= 1'b0;
                    end else if (start) begin
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            r_snap[i] <= w_score[i];
                        end
                        r_best       <= w_score[0];
                        r_idx        <= '0;
                        r_ptr        <= c_IDX_W'(1);
                        r_new_record <= 1'b0;
                        r_state      <= c_S_SCAN;
                    end
                end
                c_S_SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (w_gt) begin
                        r_best <= r_snap[r_ptr];
                        r_idx  <= r_ptr;
                    end
                    if (r_ptr == c_LAST_PTR) begin
                        r_state <= c_S_CHECK;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                c_S_CHECK: begin
                    if (w_gt) begin
                        r_high_score <= r_best;
                        r_new_record <= 1'b1;
                    end
                    r_winner     <= r_idx;
                    r_best_score <= r_best;
                    r_state      <= c_S_DONE;
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign busy       = (r_state != c_S_IDLE);
    assign done       = (r_state == c_S_DONE);
    assign winner     = r_winner;
    assign best_score = r_best_score;
    assign high_score = r_high_score;
    assign new_record = r_new_record;

endmodule : high_score_ctrl
`default_nettype wire

// File: tb/tb_high_score_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_high_score_ctrl
// Brief    : Randomised self-checking bench for high_score_ctrl against a
//            list-ranking reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_high_score_ctrl;

    localparam int          c_N       = 4;
    localparam int          c_W       = 10;
    localparam logic [9:0]  c_HS_INIT = 10'd0;
    localparam int          c_IW      = $clog2(c_N);

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic [c_W*c_N-1:0]   scores = '0;
    logic                 busy;
    logic                 done;
    logic [c_IW-1:0]      winner;
    logic [c_W-1:0]       best_score;
    logic [c_W-1:0]       high_score;
    logic                 new_record;
`ifdef HS_CLEAR_EN
    logic                 clear_hs = 1'b0;
`endif

    int n_total = 0;
    int n_bad   = 0;

    // reference state
    int m_hs     = int'(c_HS_INIT);
    int m_winner = 0;
    int m_best   = 0;

    high_score_ctrl #(
        .NUM_PLAYERS (c_N),
        .HS_INIT     (c_HS_INIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .scores     (scores),
        .busy       (busy),
        .done       (done),
        .winner     (winner),
        .best_score (best_score),
        .high_score (high_score),
        .new_record (new_record)
`ifdef HS_CLEAR_EN
        ,
        .clear_hs   (clear_hs)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [c_W*c_N-1:0] pack4(input int s0, input int s1, input int s2, input int s3);
        logic [c_W*c_N-1:0] v;
        v[0*c_W +: c_W] = c_W'(s0);
        v[1*c_W +: c_W] = c_W'(s1);
        v[2*c_W +: c_W] = c_W'(s2);
        v[3*c_W +: c_W] = c_W'(s3);
        return v;
    endfunction

    // Highest score, first player to reach it wins.
    task automatic ref_rank(input logic [c_W*c_N-1:0] sc, output int w, output int b);
        int vals[$];
        for (int i = 0; i < c_N; i++) vals.push_back(int'(sc[c_W*i +: c_W]));
        b = vals.max()[0];
        w = 0;
        for (int i = c_N - 1; i >= 0; i--) if (vals[i] == b) w = i;
    endtask

    // One ranking pass. disturb: toggle start and scores during the pass and
    // hold start in the DONE cycle; neither may be accepted.
    task automatic do_pass(input string tag, input logic [c_W*c_N-1:0] sc, input bit disturb);
        int k;
        int ew, eb;
        bit erec;
        ref_rank(sc, ew, eb);
        erec = (eb > m_hs);
        scores = sc;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!done && k < 20) begin
            check({tag, " busy"}, int'(busy), 1);
            check({tag, " stable winner"}, int'(winner), m_winner);
            check({tag, " stable best"}, int'(best_score), m_best);
            if (disturb && k == 1) begin
                start  = 1'b1;
                scores = {$urandom, $urandom};
            end
            if (disturb && k == 2) start = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        check({tag, " latency"}, k, c_N);
        if (done) begin
            m_winner = ew;
            m_best   = eb;
            if (erec) m_hs = eb;
            check({tag, " winner"}, int'(winner), ew);
            check({tag, " best"}, int'(best_score), eb);
            check({tag, " hs"}, int'(high_score), m_hs);
            check({tag, " rec"}, int'(new_record), int'(erec));
            if (disturb) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check({tag, " done pulse"}, int'(done), 0);
            check({tag, " idle"}, int'(busy), 0);
            check({tag, " rec held"}, int'(new_record), int'(erec));
        end
    endtask

    initial begin
        int r;
        logic [c_W*c_N-1:0] sc;

        reset = 1'b1;
        #12;
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst winner", int'(winner), 0);
        check("rst best", int'(best_score), 0);
        check("rst hs", int'(high_score), int'(c_HS_INIT));
        check("rst rec", int'(new_record), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_pass("T2", pack4(100, 992, 809, 5), 1'b0);
        do_pass("T3", pack4(809, 809, 3, 809), 1'b0);
        do_pass("T4", pack4(0, 0, 992, 1), 1'b0);
        do_pass("T5", pack4(7, 300, 300, 12), 1'b1);

        // mid-pass asynchronous reset
        scores = pack4(50, 60, 70, 80);
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("T1 busy", int'(busy), 0);
        check("T1 done", int'(done), 0);
        check("T1 hs", int'(high_score), int'(c_HS_INIT));
        check("T1 winner", int'(winner), 0);
        check("T1 best", int'(best_score), 0);
        check("T1 rec", int'(new_record), 0);
        #2;
        reset = 1'b0;
        m_hs = int'(c_HS_INIT);
        m_winner = 0;
        m_best = 0;
        @(posedge clk); #1;

        do_pass("zero", pack4(0, 0, 0, 0), 1'b0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < c_N; i++) begin
                r = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) * 300
                                                : int'($urandom_range(0, 1023));
                sc[c_W*i +: c_W] = c_W'(r);
            end
            do_pass("rand", sc, ($urandom_range(0, 3) == 0));
        end

`ifdef HS_CLEAR_EN
        do_pass("T6 pre", pack4(1023, 0, 0, 0), 1'b0);
        clear_hs = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        clear_hs = 1'b0;
        start    = 1'b0;
        m_hs = int'(c_HS_INIT);
        check("T6 no pass", int'(busy), 0);
        check("T6 hs", int'(high_score), int'(c_HS_INIT));
        check("T6 rec", int'(new_record), 0);
        do_pass("T6 post", pack4(1, 0, 0, 0), 1'b0);
        check("T6 rec set", int'(new_record), 1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_high_score_ctrl
`default_nettype wire
